// File: rtl/rv32_ram_arbiter.sv
// rv32_ram_arbiter: shares one single-port synchronous-read RAM between the
// RV32I instruction-fetch port and the load/store port. Data has priority,
// bounded by an anti-starvation limit for fetch. Sub-word stores become a
// two-cycle read-modify-write because the RAM has only a whole-word write enable.
// Optional feature macro: RV32_RAM_ARB_ERR_EN (adds d_err; out-of-range or
// misaligned data accesses are granted but suppressed and flagged).
module rv32_ram_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [31:0]         if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_dout
`ifdef RV32_RAM_ARB_ERR_EN
  ,
  output logic                d_err
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                if_rvalid_q;
  logic                d_rvalid_q;

  logic                idle;
  logic                d_win;
  logic [ADDR_W-1:0]   d_idx;
  logic [ADDR_W-1:0]   if_idx;
  logic                be_full;
  logic                be_none;
  logic                be_part;
  logic                d_bad;
  logic                unused_bits;

  // Byte-wise merge of new store lanes over the word read back from RAM.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] nw,
                                                    input logic [DATA_W-1:0] old,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = nw[8*i +: 8];
    end
    return res;
  endfunction

`ifdef RV32_RAM_ARB_ERR_EN
  // Legal partial-store lane patterns: a single byte or an aligned halfword.
  function automatic logic be_legal_partial(input logic [BE_W-1:0] be);
    logic ok;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic d_err_q;

  assign d_bad = (d_addr[31:ADDR_W+2] != '0) ||
                 ((!d_we || be_full) && (d_addr[1:0] != 2'b00)) ||
                 (d_we && be_part && !be_legal_partial(d_be));
  assign d_err = d_err_q;
`else
  assign d_bad = 1'b0;
`endif

  // Low and high byte-address bits only matter for error detection.
  assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         d_addr[31:ADDR_W+2], d_addr[1:0]};

  assign idle    = (state_q == IDLE);
  assign d_idx   = d_addr[ADDR_W+1:2];
  assign if_idx  = if_addr[ADDR_W+1:2];
  assign be_full = (d_be == '1);
  assign be_none = (d_be == '0);
  assign be_part = !be_full && !be_none;

  // Data wins unless fetch is waiting and data already took its quota.
  assign d_win  = d_req && (!if_req || (cnt_q < CNT_W'(STARVE_LIM)));
  assign d_gnt  = rst_n && idle && d_win;
  assign if_gnt = rst_n && idle && if_req && !d_win;

  // RAM address follows the current grant, otherwise the last address
  // (which during RMW_WR is the latched store index).
  always_comb begin
    ram_addr = addr_q;
    if (d_gnt)       ram_addr = d_idx;
    else if (if_gnt) ram_addr = if_idx;
  end

  assign ram_we  = rst_n && (idle ? (d_gnt && d_we && be_full && !d_bad) : 1'b1);
  assign ram_din = idle ? d_wdata : merge_bytes(wdata_q, ram_dout, be_q);

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = ram_dout;
  assign d_rdata   = ram_dout;

  // Latch address and store payload at grant time; not reset.
  always_ff @(posedge clk) begin
    if (d_gnt) begin
      addr_q  <= d_idx;
      be_q    <= d_be;
      wdata_q <= d_wdata;
    end else if (if_gnt) begin
      addr_q  <= if_idx;
    end
  end

  // Arbitration FSM, starvation counter and registered valid/error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
`ifdef RV32_RAM_ARB_ERR_EN
      d_err_q     <= 1'b0;
`endif
    end else begin
      state_q     <= (d_gnt && d_we && be_part && !d_bad) ? RMW_WR : IDLE;
      if (!if_req || if_gnt) cnt_q <= '0;
      else if (d_gnt)        cnt_q <= cnt_q + 1'b1;
      if_rvalid_q <= if_gnt;
      d_rvalid_q  <= d_gnt && !d_we && !d_bad;
`ifdef RV32_RAM_ARB_ERR_EN
      d_err_q     <= d_gnt && d_bad;
`endif
    end
  end

endmodule

// File: tb/tb_rv32_ram_arbiter.sv
// Self-checking bench for rv32_ram_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_rv32_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
`ifdef RV32_RAM_ARB_ERR_EN
  logic        d_err;
`endif

  always #5 clk = ~clk;

  rv32_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
`ifdef RV32_RAM_ARB_ERR_EN
    , .d_err(d_err)
`endif
  );

  // Behavioural single-port RAM, synchronous read, read-first.
  logic [31:0] mem [512];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level).
  bit [31:0] ref_mem   [512];
  bit        ref_known [512];
  bit        stall;
  int        st_idx;
  bit [3:0]  st_be;
  bit [31:0] st_wd;
  int        cnt;
  bit        last_dg, last_ig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] lane_merge(input bit [31:0] nw, input bit [31:0] old,
                                           input bit [3:0] be);
    bit [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  function automatic bit access_bad(input bit we, input bit [3:0] be, input bit [31:0] a);
`ifdef RV32_RAM_ARB_ERR_EN
    bit part;
    part = (be != 4'hF) && (be != 4'h0);
    if (a[31:11] != 0) return 1'b1;
    if ((!we || be == 4'hF) && a[1:0] != 0) return 1'b1;
    if (we && part && !(be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC})) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_d(input bit req, input bit we, input bit [3:0] be,
                       input bit [31:0] a, input bit [31:0] wd);
    d_req = req; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
  endtask

  task automatic set_i(input bit req, input bit [31:0] a);
    if_req = req; if_addr = a;
  endtask

  // One clock cycle: check combinational grant/RAM outputs mid-cycle, then
  // registered valid/data/error outputs just after the rising edge.
  task automatic tick();
    bit ed, ei, bad;
    int di, ii;
    bit pi_v, pi_k, pd_v, pd_k, pe;
    bit [31:0] pi_d, pd_d, mg;
    pi_v = 0; pi_k = 0; pd_v = 0; pd_k = 0; pe = 0; pi_d = 0; pd_d = 0;
    ed = 0; ei = 0;
    #2;
    di = int'(d_addr[10:2]);
    ii = int'(if_addr[10:2]);
    if (!rst_n) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_ram_we", ram_we, 0);
      stall = 0;
      cnt = 0;
    end else if (stall) begin
      mg = lane_merge(st_wd, ref_mem[st_idx], st_be);
      chk("stall_if_gnt", if_gnt, 0);
      chk("stall_d_gnt", d_gnt, 0);
      chk("rmw_we", ram_we, 1);
      chk("rmw_addr", 32'(ram_addr), 32'(st_idx));
      if (ref_known[st_idx]) chk("rmw_din", ram_din, mg);
      ref_mem[st_idx] = mg;
      stall = 0;
      if (!if_req) cnt = 0;
    end else begin
      ed  = d_req && (!if_req || cnt < 4);
      ei  = if_req && !ed;
      bad = access_bad(d_we, d_be, d_addr);
      chk("d_gnt", d_gnt, 32'(ed));
      chk("if_gnt", if_gnt, 32'(ei));
      if (ed) begin
        if (bad) begin
          chk("err_we", ram_we, 0);
          pe = 1;
        end else if (!d_we) begin
          chk("ld_we", ram_we, 0);
          chk("ld_addr", 32'(ram_addr), 32'(di));
          pd_v = 1; pd_k = ref_known[di]; pd_d = ref_mem[di];
        end else if (d_be == 4'hF) begin
          chk("sw_we", ram_we, 1);
          chk("sw_addr", 32'(ram_addr), 32'(di));
          chk("sw_din", ram_din, d_wdata);
          ref_mem[di] = d_wdata; ref_known[di] = 1;
        end else if (d_be == 4'h0) begin
          chk("nop_we", ram_we, 0);
        end else begin
          chk("rmw_rd_we", ram_we, 0);
          chk("rmw_rd_addr", 32'(ram_addr), 32'(di));
          stall = 1; st_idx = di; st_be = d_be; st_wd = d_wdata;
        end
      end else if (ei) begin
        chk("if_we", ram_we, 0);
        chk("if_addr", 32'(ram_addr), 32'(ii));
        pi_v = 1; pi_k = ref_known[ii]; pi_d = ref_mem[ii];
      end else begin
        chk("idle_we", ram_we, 0);
      end
      if (!if_req || ei) cnt = 0;
      else if (ed) cnt++;
    end
    last_dg = ed;
    last_ig = ei;
    @(posedge clk);
    #1;
    chk("if_rvalid", if_rvalid, 32'(pi_v));
    if (pi_v && pi_k) chk("if_rdata", if_rdata, pi_d);
    chk("d_rvalid", d_rvalid, 32'(pd_v));
    if (pd_v && pd_k) chk("d_rdata", d_rdata, pd_d);
`ifdef RV32_RAM_ARB_ERR_EN
    chk("d_err", d_err, 32'(pe));
`endif
    @(negedge clk);
  endtask

  bit [3:0]  be_tab [10] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};
  bit [31:0] saved;

  initial begin
    stall = 0; cnt = 0; last_dg = 0; last_ig = 0;
    rst_n = 0;
    set_i(1, 32'h0);
    set_d(1, 1, 4'hF, 32'h0, 32'hA5A5_0000);
    @(negedge clk);

    // Reset held with both requests active.
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1;
    set_i(0, 32'h0);
    tick();  // first cycle after release: data store to word 0

    // Fill words 1..15 with known contents.
    for (int w = 1; w < 16; w++) begin
      set_d(1, 1, 4'hF, 32'(w * 4), $urandom);
      tick();
    end

    // Full store then load at the top word.
    set_d(1, 1, 4'hF, 32'h7FC, 32'hDEAD_BEEF);
    tick();
    chk("top_word_mem", mem[511], 32'hDEAD_BEEF);
    set_d(1, 0, 4'hF, 32'h7FC, 32'h0);
    tick();
    chk("top_word_load", d_rdata, 32'hDEAD_BEEF);

    // Byte store via read-modify-write with fetch waiting.
    set_d(1, 1, 4'hF, 32'h7F0, 32'h1122_3344);
    tick();
    set_d(1, 1, 4'b0100, 32'h7F0, 32'h00AA_0000);
    set_i(1, 32'h0);
    tick();
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    tick();  // stall cycle
    tick();  // fetch granted
    chk("sb_merge", mem[508], 32'h11AA_3344);
    set_d(1, 0, 4'hF, 32'h7F0, 32'h0);
    set_i(0, 32'h0);
    tick();
    chk("sb_load", d_rdata, 32'h11AA_3344);

    // Starvation limit: both requests held continuously.
    set_d(1, 0, 4'hF, 32'h8, 32'h0);
    set_i(1, 32'h4);
    for (int k = 0; k < 12; k++) tick();

    // Pipelined fetch on consecutive cycles.
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      set_i(1, 32'(k * 4));
      tick();
    end
    set_i(0, 32'h0);
    tick();

    // Reset asserted in the RMW write cycle.
    saved = mem[5];
    set_d(1, 1, 4'b0001, 32'h14, 32'h0000_00FF);
    tick();
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    chk("rst_rmw_unchanged", mem[5], saved);

`ifdef RV32_RAM_ARB_ERR_EN
    // Misaligned load is granted, flagged and produces no data.
    set_d(1, 0, 4'hF, 32'h7FE, 32'h0);
    tick();
    chk("err_flag", d_err, 1);
    chk("err_no_rvalid", d_rvalid, 0);
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
`endif

    // Randomized traffic; requesters hold until granted.
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    set_i(0, 32'h0);
    last_dg = 0; last_ig = 0;
    for (int k = 0; k < 400; k++) begin
      if (!d_req || last_dg)
        set_d($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              be_tab[$urandom_range(0, 9)], 32'($urandom_range(0, 15) * 4), $urandom);
      if (!if_req || last_ig)
        set_i($urandom_range(0, 2) != 0, 32'($urandom_range(0, 15) * 4));
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end
    rst_n = 1;
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    set_i(0, 32'h0);
    tick();
    tick();
    for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_mem[w]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_ram_arbiter.md
Name: rv32_ram_arbiter

Overview:
- Shares the single-port 512x32 data/instruction RAM between the RV32I instruction-fetch port and the load/store port.
- Converts byte addresses to word indices.
- Arbitrates with data priority and an anti-starvation limit.
- Implements SB/SH byte-enable writes as read-modify-write, because the RAM has only a whole-word write_en.
- Sits between the core's fetch/LSU and the RAM instance.

Parameters:
- ADDR_W, 9, RAM word-address width (512 words).
- DATA_W, 32, word width.
- STARVE_LIM, 4, maximum consecutive data grants while fetch waits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetch instruction word
- d_req  in  1  load/store request
- d_we  in  1  1=store, 0=load
- d_be  in  4  store byte enables, bit i = byte i (little endian)
- d_addr  in  32  load/store byte address
- d_wdata  in  32  store data, lanes already positioned per d_be
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load word
- ram_addr  out  ADDR_W  RAM word address
- ram_din  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DATA_W  RAM read data (synchronous read: valid cycle after address)

Behaviour:
- Reset (rst_n low at a rising clk):
  - State goes to IDLE; starvation counter = 0; if_rvalid/d_rvalid = 0.
  - if_gnt, d_gnt and ram_we are gated with rst_n combinationally, so they are 0 in any cycle rst_n is low.
- Addressing: ram_addr = addr[ADDR_W+1:2]. addr[1:0] and addr[31:ADDR_W+2] are ignored (see optional feature).
- Handshake:
  - A requester holds req/addr/data until it sees gnt high in the same cycle.
  - On gnt, the block latches what it needs; the requester may change inputs next cycle.
- States: IDLE (accepting) and RMW_WR (stall).
- Grant in IDLE, priority:
  1. If d_req and (!if_req or cnt < STARVE_LIM): grant data.
  2. Else if if_req: grant fetch.
  - cnt increments on each data grant while if_req is high; it clears on a fetch grant or whenever if_req is low.
- Read, load or fetch, granted at cycle N:
  - ram_addr = word index, ram_we = 0 in cycle N.
  - Matching rvalid = 1 and rdata = ram_dout in cycle N+1 only.
  - Back-to-back reads every cycle are allowed (fully pipelined).
- Full store (d_be = 4'hF) granted at N: ram_we = 1, ram_din = d_wdata in cycle N. No rvalid. Next grant is possible at N+1.
- Partial store (d_be != 4'hF and != 0) granted at N:
  - Cycle N: read issued, ram_we = 0; addr/be/wdata latched; go to RMW_WR.
  - Cycle N+1: ram_addr = latched index, ram_din = per-byte merge (byte i from wdata if be[i], else from ram_dout), ram_we = 1. No grants. Return to IDLE.
- d_be = 0 store: granted and completed in one cycle with ram_we = 0 (no-op).
- Read-after-write to the same address is naturally ordered: a load granted at N+2 after an RMW started at N sees the merged word.
- Reset asserted during RMW_WR: the merged write is suppressed (ram_we gated) and the state returns to IDLE.
- When no grant occurs in IDLE: ram_we = 0, and ram_addr holds its last value (don't-care).

Optional Feature:
- Macro: RV32_RAM_ARB_ERR_EN.
- When defined:
  - Adds output d_err (1 bit, reset 0).
  - A data request with nonzero addr[31:ADDR_W+2], or misaligned for its type, is still granted. Misaligned means: any addr[1:0] != 0 on loads and full stores; be not contiguous within the addressed half/word for partial stores.
  - For such a request, d_err pulses in cycle N+1, ram_we stays 0 throughout (no RMW entered), and d_rvalid stays 0.
- When undefined: no d_err port; these accesses proceed with the ignored address bits.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both reqs high -> if_gnt, d_gnt, ram_we, if_rvalid, d_rvalid all 0; first cycle after release grants data.
- Full store then load: store d_addr=0x7FC, data 0xDEADBEEF, be=F -> ram_addr=511, ram_we=1 in one cycle. Load 0x7FC -> d_rvalid next cycle with 0xDEADBEEF.
- SB RMW: word 508 holds 0x11223344; store be=4'b0100, wdata=0x00AA0000 at 0x7F0 -> one-cycle stall, RAM ends 0x11AA3344; if_gnt low in the stall cycle.
- Starvation: if_req and d_req held high continuously -> exactly 4 d_gnt, then 1 if_gnt, pattern repeats.
- Pipelined fetch: 4 fetches at 0x000,0x004,0x008,0x00C on consecutive cycles -> if_gnt every cycle, if_rvalid cycles N+1..N+4 in order.
- Reset mid-RMW: partial store granted, rst_n=0 in the next cycle -> ram_we stays 0, RAM word unchanged; with RV32_RAM_ARB_ERR_EN, a load at 0x7FE gives d_err=1, d_rvalid=0.
